// File: rtl/normalization_if.sv
// Sample bus for the normalization stage: a signed wide filter result in,
// an unsigned 8-bit pixel out. The filter side drives A, the normalizer
// drives out.
interface normalization_if #(
    parameter int norm_width = 15
);
    logic signed [norm_width:0] A;
    logic        [7:0]          out;

    // Producer of samples / consumer of pixels
    modport master (
        output A,
        input  out
    );

    // The normalizer itself
    modport slave (
        input  A,
        output out
    );
endinterface

// File: rtl/normalization.sv
// Signed-to-pixel normalizer.
// Two-stage free-running pipeline: stage 1 takes the magnitude of A (or
// clamps negatives to zero), stage 2 applies an optional round-half-up
// right shift and saturates to 0..255. One sample per clock, two-clock
// latency, no handshake.
module normalization #(
    parameter int norm_width = 15,
    parameter int SHIFT      = 0,
    parameter int ABS_MODE   = 1
) (
    normalization_if.slave bus,
    input  logic           clk,
    input  logic           reset
);

    // mag carries one extra bit over A so that -2^norm_width negates cleanly;
    // the rounding sum carries one more so the bias add cannot wrap.
    localparam int MAG_W = norm_width + 2;
    localparam int SUM_W = norm_width + 3;

    // Rounding bias of half an output LSB; zero when no shift is applied.
    // The guarded exponent keeps the shift amount legal when SHIFT is 0.
    localparam int                 RND_EXP   = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam logic [SUM_W-1:0]   RND_BIAS  = (SHIFT > 0) ? (SUM_W'(1) << RND_EXP)
                                                           : SUM_W'(0);
    localparam logic [SUM_W-1:0]   PIX_MAX   = SUM_W'(255);

    logic             a_neg;
    logic [MAG_W-1:0] a_ext;
    logic [MAG_W-1:0] mag_d;
    logic [MAG_W-1:0] mag_q;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] shifted;
    logic [7:0]       pix_d;
    logic [7:0]       pix_q;

    // Stage 1 combinational: sign-extend A one bit and form its magnitude.
    always_comb begin
        a_neg = bus.A[norm_width];
        a_ext = {bus.A[norm_width], bus.A};
        mag_d = a_ext;
        if (a_neg) begin
            if (ABS_MODE != 0) begin
                mag_d = MAG_W'(0) - a_ext;
            end else begin
                mag_d = '0;
            end
        end
    end

    // Stage 1 register: magnitude of the sample captured this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    // Stage 2 combinational: round-half-up shift, then clamp to the pixel range.
    always_comb begin
        sum     = {1'b0, mag_q} + RND_BIAS;
        shifted = sum >> SHIFT;
        if (shifted > PIX_MAX) begin
            pix_d = 8'hFF;
        end else begin
            pix_d = shifted[7:0];
        end
    end

    // Stage 2 register: the output pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign bus.out = pix_q;

endmodule

// File: tb/tb_normalization.sv
// Bench for the normalizer: three instances (default, clamp-negatives,
// shift-by-2) share one stimulus stream and are compared every clock
// against an arithmetic reference with a two-edge delay model.
module tb_normalization;

    localparam int NW = 15;

    logic clk;
    logic reset;

    normalization_if #(.norm_width(NW)) bus_def ();
    normalization_if #(.norm_width(NW)) bus_ab0 ();
    normalization_if #(.norm_width(NW)) bus_sh2 ();

    normalization #(.norm_width(NW), .SHIFT(0), .ABS_MODE(1)) u_def (
        .bus   (bus_def),
        .clk   (clk),
        .reset (reset)
    );

    normalization #(.norm_width(NW), .SHIFT(0), .ABS_MODE(0)) u_ab0 (
        .bus   (bus_ab0),
        .clk   (clk),
        .reset (reset)
    );

    normalization #(.norm_width(NW), .SHIFT(2), .ABS_MODE(1)) u_sh2 (
        .bus   (bus_sh2),
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    int prev_a    = 0;
    bit prev_rst  = 1'b1;
    bit primed    = 1'b0;

    // Reference: pixel value for a sample, from the stated rules.
    function automatic int ref_pix(input int a, input int shift, input int absm);
        longint m;
        if (a >= 0)          m = a;
        else if (absm != 0)  m = -a;
        else                 m = 0;
        if (shift > 0) m = (m + (longint'(1) << (shift - 1))) >>> shift;
        if (m > 255) m = 255;
        return int'(m);
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input int exp_v);
        logic [7:0] exp8;
        exp8 = exp_v[7:0];
        total_cnt++;
        assert (got === exp8) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp8);
        end
    endtask

    // Drive one sample and reset level, advance one edge, then check all three.
    task automatic step(input int a, input bit r);
        int e_def, e_ab0, e_sh2;
        bus_def.A = 16'(a);
        bus_ab0.A = 16'(a);
        bus_sh2.A = 16'(a);
        reset     = r;
        @(posedge clk);
        #1;
        if (r || prev_rst) begin
            e_def = 0; e_ab0 = 0; e_sh2 = 0;
        end else begin
            e_def = ref_pix(prev_a, 0, 1);
            e_ab0 = ref_pix(prev_a, 0, 0);
            e_sh2 = ref_pix(prev_a, 2, 1);
        end
        if (primed) begin
            check($sformatf("def  A=%0d", prev_a), bus_def.out, e_def);
            check($sformatf("abs0 A=%0d", prev_a), bus_ab0.out, e_ab0);
            check($sformatf("sh2  A=%0d", prev_a), bus_sh2.out, e_sh2);
        end
        if (r) primed = 1'b1;
        prev_a   = a;
        prev_rst = r;
    endtask

    initial begin
        int rv;
        bit rr;
        reset = 1'b1;
        bus_def.A = '0;
        bus_ab0.A = '0;
        bus_sh2.A = '0;
        #2;

        // Reset held two edges with a nonzero input, then release.
        step(1000, 1);
        step(1000, 1);
        step(234, 0);
        step(234, 0);
        step(234, 0);
        step(0, 0);
        step(0, 0);

        // Negative and back-to-back stream.
        step(-192, 0);
        step(234, 0);
        step(-192, 0);
        step(300, 0);
        step(-5, 0);

        // Extremes and saturation boundaries.
        step(32767, 0);
        step(-32768, 0);
        step(256, 0);
        step(255, 0);
        step(-255, 0);
        step(-256, 0);
        step(-1, 0);
        step(100, 0);

        // Rounding cases for the shifted instance.
        step(-6, 0);
        step(1021, 0);
        step(1017, 0);
        step(1018, 0);
        step(5, 0);
        step(6, 0);
        step(-2, 0);

        // Reset mid-stream, then recovery.
        step(500, 0);
        step(700, 1);
        step(-40, 0);
        step(77, 0);
        step(0, 0);

        // Randomized stream with occasional resets.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = $urandom_range(0, 300);
                1:       rv = -int'($urandom_range(0, 300));
                2:       rv = int'($urandom_range(0, 1200)) - 600;
                default: rv = int'($urandom_range(0, 65535)) - 32768;
            endcase
            rr = ($urandom_range(0, 31) == 0);
            step(rv, rr);
        end
        step(0, 0);
        step(0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
